// File: rtl/sp_dram_arbiter_pkg.sv
// rtl/sp_dram_arbiter_pkg.sv - shared types and widths for the scratchpad DRAM arbiter
package sp_dram_arbiter_pkg;

  localparam int DRAM_ADDR_W = 32;
  localparam int DRAM_DATA_W = 64;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} arb_state_t;
  typedef enum logic {GRANT_LOAD, GRANT_STORE} arb_grant_t;

endpackage

// File: rtl/sp_dram_arbiter_if.sv
// rtl/sp_dram_arbiter_if.sv - scratchpad request/response and DRAM channel signal bundle
interface sp_dram_arbiter_if #(
  parameter int ADDR_W = sp_dram_arbiter_pkg::DRAM_ADDR_W,
  parameter int DATA_W = sp_dram_arbiter_pkg::DRAM_DATA_W
);
  logic              s_load;
  logic [ADDR_W-1:0] load_addr;
  logic              s_store;
  logic [ADDR_W-1:0] store_addr;
  logic [DATA_W-1:0] store_data;
  logic              s_load_hit;
  logic [DATA_W-1:0] load_data;
  logic              s_store_hit;
  logic              dram_req;
  logic              dram_wen;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_wdata;
  logic              dram_ready;
  logic [DATA_W-1:0] dram_rdata;

  // The arbiter side: consumes scratchpad requests, drives the DRAM channel.
  modport slave (
    input  s_load, load_addr, s_store, store_addr, store_data, dram_ready, dram_rdata,
    output s_load_hit, load_data, s_store_hit, dram_req, dram_wen, dram_addr, dram_wdata
  );

  modport master (
    output s_load, load_addr, s_store, store_addr, store_data, dram_ready, dram_rdata,
    input  s_load_hit, load_data, s_store_hit, dram_req, dram_wen, dram_addr, dram_wdata
  );
endinterface

// File: rtl/sp_dram_arbiter_watchdog.sv
// rtl/sp_dram_arbiter_watchdog.sv - sticky timeout flag for an outstanding DRAM request
module sp_dram_arbiter_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic          expired_q;

  // cnt_q holds how many waiting cycles have already elapsed; it parks at LIMIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      if (load_i) begin
        cnt_q <= '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (en_i && !load_i && (cnt_q == LIMIT)) begin
        expired_q <= 1'b1;
      end
    end
  end

  assign expired_o = expired_q;
endmodule

// File: rtl/sp_dram_arbiter.sv
// rtl/sp_dram_arbiter.sv - round-robin merge of scratchpad load/store onto one DRAM channel
module sp_dram_arbiter
  import sp_dram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DRAM_ADDR_W,
  parameter int DATA_W  = DRAM_DATA_W,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  sp_dram_arbiter_if.slave   bus_io,
  output logic               err_o,
  output logic [CNT_W-1:0]   load_cnt_o,
  output logic [CNT_W-1:0]   store_cnt_o
);
  arb_state_t        state_q, state_d;
  arb_grant_t        last_q, last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  lcnt_q, scnt_q;
  logic              busy, grant, done;

  // last_q doubles as the side currently in flight, since it is updated on every grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= GRANT_STORE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus_io.s_load && (!bus_io.s_store || (last_q == GRANT_STORE))) begin
          state_d = LOAD;
          last_d  = GRANT_LOAD;
        end else if (bus_io.s_store) begin
          state_d = STORE;
          last_d  = GRANT_STORE;
        end
      end
      LOAD, STORE: begin
        if (bus_io.dram_ready) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == LOAD) || (state_q == STORE);
    grant = (state_q == IDLE) && (state_d != IDLE);
    done  = busy && bus_io.dram_ready;
    bus_io.dram_req    = busy;
    bus_io.dram_wen    = (state_q == STORE);
    bus_io.dram_addr   = addr_q;
    bus_io.dram_wdata  = wdata_q;
    bus_io.load_data   = rdata_q;
    // A request dropped mid-flight means the scratchpad no longer wants the hit.
    bus_io.s_load_hit  = (state_q == RESP) && (last_q == GRANT_LOAD) && bus_io.s_load;
    bus_io.s_store_hit = (state_q == RESP) && (last_q == GRANT_STORE) && bus_io.s_store;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      if (grant) begin
        addr_q <= (state_d == LOAD) ? bus_io.load_addr : bus_io.store_addr;
        if (state_d == STORE) wdata_q <= bus_io.store_data;
      end
      if (done && (state_q == LOAD)) begin
        rdata_q <= bus_io.dram_rdata;
        lcnt_q  <= lcnt_q + 1'b1;
      end
      if (done && (state_q == STORE)) begin
        scnt_q <= scnt_q + 1'b1;
      end
    end
  end

  sp_dram_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (grant),
    .en_i      (busy && !bus_io.dram_ready),
    .expired_o (err_o)
  );

  assign load_cnt_o  = lcnt_q;
  assign store_cnt_o = scnt_q;
endmodule

// File: tb/tb_sp_dram_arbiter.sv
// tb/tb_sp_dram_arbiter.sv - directed bench with a transaction-level reference model
module tb_sp_dram_arbiter;
  localparam int TO = 20;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  logic [CW-1:0] load_cnt, store_cnt;

  sp_dram_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  sp_dram_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus_io      (bus),
    .err_o       (err),
    .load_cnt_o  (load_cnt),
    .store_cnt_o (store_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: one transaction owns the channel until DRAM completes it,
  // followed by a single response cycle before the channel is free again.
  typedef enum int {M_NONE, M_LOAD, M_STORE} side_e;
  side_e       m_txn = M_NONE;
  side_e       m_resp_side = M_NONE;
  bit          m_resp = 0;
  bit          m_last_load = 0;
  logic [31:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [63:0] m_rdata = '0;
  int          m_lcnt = 0, m_scnt = 0, m_wait = 0;
  bit          m_err = 0;
  side_e       take;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_txn = M_NONE; m_resp = 0; m_last_load = 0; m_addr = '0; m_wdata = '0;
      m_rdata = '0; m_lcnt = 0; m_scnt = 0; m_wait = 0; m_err = 0;
    end else if (m_txn != M_NONE) begin
      if (bus.dram_ready) begin
        if (m_txn == M_LOAD) begin
          m_rdata = bus.dram_rdata;
          m_lcnt  = (m_lcnt + 1) % (1 << CW);
        end else begin
          m_scnt = (m_scnt + 1) % (1 << CW);
        end
        m_resp_side = m_txn;
        m_resp = 1;
        m_txn = M_NONE;
      end else begin
        m_wait++;
        if (m_wait >= TO) m_err = 1;
      end
    end else if (m_resp) begin
      m_resp = 0;
    end else begin
      if (bus.s_load && bus.s_store) take = m_last_load ? M_STORE : M_LOAD;
      else if (bus.s_load)           take = M_LOAD;
      else if (bus.s_store)          take = M_STORE;
      else                           take = M_NONE;
      if (take != M_NONE) begin
        m_txn = take;
        m_last_load = (take == M_LOAD);
        m_addr = (take == M_LOAD) ? bus.load_addr : bus.store_addr;
        if (take == M_STORE) m_wdata = bus.store_data;
        m_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("dram_req", 64'(bus.dram_req), 64'(m_txn != M_NONE));
    if (m_txn != M_NONE) begin
      chk("dram_wen", 64'(bus.dram_wen), 64'(m_txn == M_STORE));
      chk("dram_addr", 64'(bus.dram_addr), 64'(m_addr));
      if (m_txn == M_STORE) chk("dram_wdata", bus.dram_wdata, m_wdata);
    end
    chk("load_hit", 64'(bus.s_load_hit), 64'(m_resp && m_resp_side == M_LOAD && bus.s_load));
    chk("store_hit", 64'(bus.s_store_hit), 64'(m_resp && m_resp_side == M_STORE && bus.s_store));
    chk("load_data", bus.load_data, m_rdata);
    chk("load_cnt", 64'(load_cnt), 64'(m_lcnt));
    chk("store_cnt", 64'(store_cnt), 64'(m_scnt));
    chk("err", 64'(err), 64'(m_err));
  end

  // DRAM responder: ready arrives rsp_delay cycles after the request rises; -1 withholds it.
  int          rsp_delay = 0;
  logic [63:0] rsp_rdata = '0;
  int          wait_c = 0;
  int          spur_n = 0, spur_done = 0;

  always @(negedge clk) begin
    if (bus.dram_ready) begin
      bus.dram_ready = 1'b0;
    end else if (bus.dram_req) begin
      if (rsp_delay >= 0) begin
        if (wait_c >= rsp_delay) begin
          bus.dram_ready = 1'b1;
          bus.dram_rdata = rsp_rdata;
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end
    end else begin
      wait_c = 0;
      if (spur_n != spur_done) begin
        bus.dram_ready = 1'b1;
        bus.dram_rdata = 64'hBAD0_BAD0;
        spur_done++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  bit seen[$];
  int n_lhit, n_shit;

  task automatic run_until_idle(input int budget);
    int  n = 0;
    bit  prev_req = bus.dram_req;
    bit  ok = 0;
    seen.delete();
    n_lhit = 0;
    n_shit = 0;
    while (n < budget && !ok) begin
      step();
      n++;
      if (bus.dram_req && !prev_req) seen.push_back(bus.dram_wen);
      prev_req = bus.dram_req;
      if (bus.s_load_hit)  begin n_lhit++; bus.s_load = 1'b0; end
      if (bus.s_store_hit) begin n_shit++; bus.s_store = 1'b0; end
      if (!bus.s_load && !bus.s_store && !bus.dram_req) ok = 1;
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    step();
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.dram_req && n < 10) begin step(); n++; end
    if (!bus.dram_req) chk(name, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.s_load = 0; bus.load_addr = '0; bus.s_store = 0; bus.store_addr = '0;
    bus.store_data = '0; bus.dram_ready = 0; bus.dram_rdata = '0;
    repeat (3) step();
    chk("rst_dram_req", 64'(bus.dram_req), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_load_cnt", 64'(load_cnt), 64'd0);
    chk("rst_store_cnt", 64'(store_cnt), 64'd0);
    rst_n = 1'b1;
    step();

    // Single load, ready 4 cycles after the request rises.
    rsp_delay = 4; rsp_rdata = 64'hDEAD;
    bus.s_load = 1; bus.load_addr = 32'h100;
    step();
    chk("t1_req", 64'(bus.dram_req), 64'd1);
    chk("t1_wen", 64'(bus.dram_wen), 64'd0);
    chk("t1_addr", 64'(bus.dram_addr), 64'h100);
    repeat (4) step();
    chk("t1_hit_early", 64'(bus.s_load_hit), 64'd0);
    step();
    chk("t1_hit", 64'(bus.s_load_hit), 64'd1);
    bus.s_load = 0;
    step();
    chk("t1_idle", 64'(bus.dram_req), 64'd0);
    chk("t1_data", bus.load_data, 64'hDEAD);
    chk("t1_cnt", 64'(load_cnt), 64'd1);

    // Simultaneous requests from reset: load first, store second, then load again.
    do_reset();
    rsp_delay = 1; rsp_rdata = 64'h5555;
    bus.s_load = 1; bus.load_addr = 32'h200;
    bus.s_store = 1; bus.store_addr = 32'h300; bus.store_data = 64'hBEEF;
    run_until_idle(30);
    chk("t2_n_txn", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) begin
      chk("t2_first_wen", 64'(seen[0]), 64'd0);
      chk("t2_second_wen", 64'(seen[1]), 64'd1);
    end
    chk("t2_lhits", 64'(n_lhit), 64'd1);
    chk("t2_shits", 64'(n_shit), 64'd1);
    bus.s_load = 1; bus.s_store = 1; bus.store_data = 64'hCAFE;
    run_until_idle(30);
    chk("t2b_n_txn", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) chk("t2b_first_wen", 64'(seen[0]), 64'd0);
    chk("t2b_load_cnt", 64'(load_cnt), 64'd2);
    chk("t2b_store_cnt", 64'(store_cnt), 64'd2);

    // Store aborted by the requester mid-flight; inputs scrambled afterwards.
    rsp_delay = 3;
    bus.s_store = 1; bus.store_addr = 32'h40; bus.store_data = 64'h1234;
    wait_req("t3_no_req");
    chk("t3_wen", 64'(bus.dram_wen), 64'd1);
    chk("t3_addr", 64'(bus.dram_addr), 64'h40);
    chk("t3_wdata", bus.dram_wdata, 64'h1234);
    step();
    bus.s_store = 0; bus.store_addr = 32'hFFF; bus.store_data = '1;
    run_until_idle(20);
    chk("t3_no_hit", 64'(n_shit), 64'd0);
    chk("t3_store_cnt", 64'(store_cnt), 64'd3);

    // Watchdog: ready withheld, err appears at cycle TO, then the load completes.
    rsp_delay = -1; rsp_rdata = 64'h7777;
    bus.s_load = 1; bus.load_addr = 32'h600;
    wait_req("t4_no_req");
    repeat (TO - 1) step();
    chk("t4_err_before", 64'(err), 64'd0);
    step();
    chk("t4_err_at", 64'(err), 64'd1);
    rsp_delay = 0;
    run_until_idle(10);
    chk("t4_hit", 64'(n_lhit), 64'd1);
    chk("t4_err_sticky", 64'(err), 64'd1);
    chk("t4_load_cnt", 64'(load_cnt), 64'd3);

    // Reset while a request is outstanding.
    rsp_delay = -1;
    bus.s_load = 1; bus.load_addr = 32'h500;
    wait_req("t5_no_req");
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req_drop", 64'(bus.dram_req), 64'd0);
    chk("t5_lhit", 64'(bus.s_load_hit), 64'd0);
    chk("t5_err_clr", 64'(err), 64'd0);
    chk("t5_cnt_clr", 64'(load_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    rsp_delay = 2; rsp_rdata = 64'h4242;
    run_until_idle(20);
    chk("t5_recover_hit", 64'(n_lhit), 64'd1);
    chk("t5_recover_cnt", 64'(load_cnt), 64'd1);

    // Spurious ready in idle, then enough loads to wrap the counter.
    spur_n++;
    repeat (3) begin
      step();
      chk("t6_spur_hit", 64'(bus.s_load_hit), 64'd0);
    end
    chk("t6_spur_cnt", 64'(load_cnt), 64'd1);
    chk("t6_spur_data", bus.load_data, 64'h4242);
    for (int i = 0; i < 15; i++) begin
      rsp_delay = i % 3;
      rsp_rdata = 64'h1000 + 64'(i);
      bus.load_addr = 32'h800 + 32'(i * 8);
      bus.s_load = 1;
      run_until_idle(30);
      chk("t6_hit", 64'(n_lhit), 64'd1);
      if (i == 13) chk("t6_pre_wrap", 64'(load_cnt), 64'd15);
    end
    chk("t6_wrap", 64'(load_cnt), 64'd0);
    chk("t6_last_data", bus.load_data, 64'h100E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
